ctl_pipe: RTL and testbench

Pipelined successor to the single-cycle RV32I control decoder. Decodes the instruction in ID, carries the control bundle through ID/EX, EX/MEM and MEM/WB stage registers, and resolves branches in EX. It also detects load-use and RAW hazards and generates stall, flush and operand-forwarding selects for the 5-stage datapath. It sits beside the datapath stage registers and drives every datapath mux.

---
 rtl/ctl_pipe.sv | 258 +++++++++++++++++++++++++
 tb/tb_ctl_pipe.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctl_pipe.sv
// ctl_pipe: pipelined RV32I control unit. Decodes in ID, carries the control
// bundle through ID/EX, EX/MEM and MEM/WB, resolves branches in EX, and
// generates stall, flush and EX operand-forwarding selects.
module ctl_pipe #(
    parameter int FWD_EN       = 1,
    parameter int ILLEGAL_TRAP = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_id,
    input  logic        inst_valid,
    input  logic        brEq,
    input  logic        brLT,
    output logic [2:0]  ImmSel,
    output logic        stall,
    output logic        flush,
    output logic        pcSel,
    output logic        ex_ASel,
    output logic        ex_BSel,
    output logic [3:0]  ex_ALUSel,
    output logic        ex_BrUn,
    output logic [1:0]  fwdA,
    output logic [1:0]  fwdB,
    output logic        mem_MemRW,
    output logic        mem_sign,
    output logic [1:0]  mem_size,
    output logic        wb_RegWEn,
    output logic [1:0]  wb_WBSel,
    output logic [4:0]  wb_rd,
    output logic        illegal
);

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OPIMM  = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_t;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_t;

    // An all-zero bundle is a bubble: no writes, no control transfer.
    typedef struct packed {
        logic       a_sel;
        logic       b_sel;
        alu_t       alu;
        logic       br_un;
        logic       mem_rw;
        logic       sign;
        logic [1:0] size;
        logic       reg_wen;
        logic [1:0] wb_sel;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic       is_load;
        logic       is_branch;
        logic       is_jump;
        logic       illegal;
    } ctl_t;

    ctl_t       dec;
    ctl_t       ex;
    logic       writes;
    logic       use_rs1;
    logic       use_rs2;
    logic       hazard;
    logic       mem_reg_wen;
    logic [1:0] mem_wb_sel;
    logic [4:0] mem_rd;
    logic       mem_is_load;
    logic       unused_bits;

    assign unused_bits = ^{inst_id[31], inst_id[29:25]};

    function automatic alu_t alu_decode(input logic [2:0] f3, input logic alt, input logic is_op);
        alu_t r;
        case (f3)
            3'b000:  r = (is_op && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    function automatic logic reads(input logic [4:0] rd, input logic wen,
                                   input logic [4:0] rs1, input logic [4:0] rs2);
        return wen && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        logic [1:0] s;
        s = 2'd0;
        if (rs != 5'd0) begin
            if (mem_reg_wen && !mem_is_load && (mem_rd == rs))
                s = 2'd1;
            else if (wb_RegWEn && (wb_rd == rs))
                s = 2'd2;
        end
        return s;
    endfunction

    // ID decode: control bundle and immediate format; unused source fields are
    // zeroed so hazard and forwarding logic only sees registers actually read.
    always_comb begin
        dec     = '0;
        ImmSel  = 3'd0;
        writes  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        if (inst_valid) begin
            dec.funct3 = inst_id[14:12];
            case (inst_id[6:0])
                OPC_LUI: begin
                    ImmSel = 3'd3; dec.b_sel = 1'b1; dec.alu = ALU_PASSB;
                    dec.wb_sel = 2'd1; writes = 1'b1;
                end
                OPC_AUIPC: begin
                    ImmSel = 3'd3; dec.a_sel = 1'b1; dec.b_sel = 1'b1;
                    dec.wb_sel = 2'd1; writes = 1'b1;
                end
                OPC_JAL: begin
                    ImmSel = 3'd4; dec.a_sel = 1'b1; dec.b_sel = 1'b1;
                    dec.wb_sel = 2'd2; writes = 1'b1; dec.is_jump = 1'b1;
                end
                OPC_JALR: begin
                    dec.b_sel = 1'b1; dec.wb_sel = 2'd2; writes = 1'b1;
                    dec.is_jump = 1'b1; use_rs1 = 1'b1;
                end
                OPC_BRANCH: begin
                    ImmSel = 3'd2; dec.a_sel = 1'b1; dec.b_sel = 1'b1;
                    dec.is_branch = 1'b1; dec.br_un = inst_id[13];
                    use_rs1 = 1'b1; use_rs2 = 1'b1;
                end
                OPC_LOAD: begin
                    dec.b_sel = 1'b1; writes = 1'b1; dec.is_load = 1'b1;
                    dec.sign = ~inst_id[14]; dec.size = inst_id[13:12]; use_rs1 = 1'b1;
                end
                OPC_STORE: begin
                    ImmSel = 3'd1; dec.b_sel = 1'b1; dec.mem_rw = 1'b1;
                    dec.size = inst_id[13:12]; use_rs1 = 1'b1; use_rs2 = 1'b1;
                end
                OPC_OPIMM: begin
                    dec.b_sel = 1'b1; dec.wb_sel = 2'd1; writes = 1'b1; use_rs1 = 1'b1;
                    dec.alu = alu_decode(inst_id[14:12], inst_id[30], 1'b0);
                end
                OPC_OP: begin
                    dec.wb_sel = 2'd1; writes = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                    dec.alu = alu_decode(inst_id[14:12], inst_id[30], 1'b1);
                end
                default: dec.illegal = 1'b1;
            endcase
        end
        dec.reg_wen = writes && (inst_id[11:7] != 5'd0);
        dec.rd      = dec.reg_wen ? inst_id[11:7] : 5'd0;
        dec.rs1     = use_rs1 ? inst_id[19:15] : 5'd0;
        dec.rs2     = use_rs2 ? inst_id[24:20] : 5'd0;
    end

    // EX branch resolution: jumps always taken, branches per funct3.
    always_comb begin
        pcSel = 1'b0;
        if (ex.is_jump) begin
            pcSel = 1'b1;
        end else if (ex.is_branch) begin
            case (ex.funct3)
                3'b000:         pcSel = brEq;
                3'b001:         pcSel = ~brEq;
                3'b100, 3'b110: pcSel = brLT;
                3'b101, 3'b111: pcSel = ~brLT;
                default:        pcSel = 1'b0;
            endcase
        end
    end

    // Hazard detection: load-use only with forwarding, any in-flight RAW without.
    always_comb begin
        hazard = 1'b0;
        if (FWD_EN != 0)
            hazard = ex.is_load && reads(ex.rd, ex.reg_wen, dec.rs1, dec.rs2);
        else
            hazard = reads(ex.rd, ex.reg_wen, dec.rs1, dec.rs2)
                   || reads(mem_rd, mem_reg_wen, dec.rs1, dec.rs2)
                   || reads(wb_rd, wb_RegWEn, dec.rs1, dec.rs2);
    end

    // EX operand forwarding selects; MEM result takes priority over WB.
    always_comb begin
        fwdA = 2'd0;
        fwdB = 2'd0;
        if (FWD_EN != 0) begin
            fwdA = fwd_sel(ex.rs1);
            fwdB = fwd_sel(ex.rs2);
        end
    end

    assign flush = pcSel;
    assign stall = hazard && !pcSel;

    // Stage registers: ID/EX takes a bubble on flush or stall; later stages always advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex          <= '0;
            mem_MemRW   <= 1'b0;
            mem_sign    <= 1'b0;
            mem_size    <= 2'd0;
            mem_reg_wen <= 1'b0;
            mem_wb_sel  <= 2'd0;
            mem_rd      <= 5'd0;
            mem_is_load <= 1'b0;
            wb_RegWEn   <= 1'b0;
            wb_WBSel    <= 2'd0;
            wb_rd       <= 5'd0;
        end else begin
            ex          <= (pcSel || hazard) ? '0 : dec;
            mem_MemRW   <= ex.mem_rw;
            mem_sign    <= ex.sign;
            mem_size    <= ex.size;
            mem_reg_wen <= ex.reg_wen;
            mem_wb_sel  <= ex.wb_sel;
            mem_rd      <= ex.rd;
            mem_is_load <= ex.is_load;
            wb_RegWEn   <= mem_reg_wen;
            wb_WBSel    <= mem_wb_sel;
            wb_rd       <= mem_rd;
        end
    end

    assign ex_ASel   = ex.a_sel;
    assign ex_BSel   = ex.b_sel;
    assign ex_ALUSel = ex.alu;
    assign ex_BrUn   = ex.br_un;
    assign illegal   = (ILLEGAL_TRAP != 0) ? ex.illegal : 1'b0;

endmodule

// File: tb/tb_ctl_pipe.sv
// tb_ctl_pipe: randomized instruction streams into two ctl_pipe instances
// (forwarding/no-trap and stalling/trap), checked cycle by cycle against an
// instruction-level pipeline model through per-instance scoreboard queues.
module tb_ctl_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, brEq, brLT;
    logic [31:0] inst0, inst1;
    logic        valid0, valid1;

    logic [2:0] ImmSel0, ImmSel1;
    logic       stall0, stall1, flush0, flush1, pcSel0, pcSel1;
    logic       ex_ASel0, ex_ASel1, ex_BSel0, ex_BSel1;
    logic [3:0] ex_ALUSel0, ex_ALUSel1;
    logic       ex_BrUn0, ex_BrUn1;
    logic [1:0] fwdA0, fwdA1, fwdB0, fwdB1;
    logic       mem_MemRW0, mem_MemRW1, mem_sign0, mem_sign1;
    logic [1:0] mem_size0, mem_size1;
    logic       wb_RegWEn0, wb_RegWEn1;
    logic [1:0] wb_WBSel0, wb_WBSel1;
    logic [4:0] wb_rd0, wb_rd1;
    logic       illegal0, illegal1;

    ctl_pipe #(.FWD_EN(1), .ILLEGAL_TRAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .inst_id(inst0), .inst_valid(valid0),
        .brEq(brEq), .brLT(brLT), .ImmSel(ImmSel0), .stall(stall0), .flush(flush0),
        .pcSel(pcSel0), .ex_ASel(ex_ASel0), .ex_BSel(ex_BSel0), .ex_ALUSel(ex_ALUSel0),
        .ex_BrUn(ex_BrUn0), .fwdA(fwdA0), .fwdB(fwdB0), .mem_MemRW(mem_MemRW0),
        .mem_sign(mem_sign0), .mem_size(mem_size0), .wb_RegWEn(wb_RegWEn0),
        .wb_WBSel(wb_WBSel0), .wb_rd(wb_rd0), .illegal(illegal0)
    );

    ctl_pipe #(.FWD_EN(0), .ILLEGAL_TRAP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .inst_id(inst1), .inst_valid(valid1),
        .brEq(brEq), .brLT(brLT), .ImmSel(ImmSel1), .stall(stall1), .flush(flush1),
        .pcSel(pcSel1), .ex_ASel(ex_ASel1), .ex_BSel(ex_BSel1), .ex_ALUSel(ex_ALUSel1),
        .ex_BrUn(ex_BrUn1), .fwdA(fwdA1), .fwdB(fwdB1), .mem_MemRW(mem_MemRW1),
        .mem_sign(mem_sign1), .mem_size(mem_size1), .wb_RegWEn(wb_RegWEn1),
        .wb_WBSel(wb_WBSel1), .wb_rd(wb_rd1), .illegal(illegal1)
    );

    typedef struct packed {
        logic [2:0] imm;
        logic       stall, flush, pc_sel, a_sel, b_sel;
        logic [3:0] alu;
        logic       br_un;
        logic [1:0] fwd_a, fwd_b;
        logic       mem_rw, sign;
        logic [1:0] size;
        logic       reg_wen;
        logic [1:0] wb_sel;
        logic [4:0] rd;
        logic       illegal;
    } outs_t;

    // One instruction's architectural meaning, as the model tracks it.
    typedef struct packed {
        logic       w;
        logic [4:0] rd, rs1, rs2;
        logic       ld, jmp, br;
        logic [2:0] f3;
        logic       a_sel, b_sel;
        logic [3:0] alu;
        logic       br_un, st, sgn;
        logic [1:0] sz, wbs;
        logic       ill;
        logic [2:0] imm;
    } ins_t;

    outs_t act0, act1;
    assign act0 = {ImmSel0, stall0, flush0, pcSel0, ex_ASel0, ex_BSel0, ex_ALUSel0, ex_BrUn0,
                   fwdA0, fwdB0, mem_MemRW0, mem_sign0, mem_size0, wb_RegWEn0, wb_WBSel0,
                   wb_rd0, illegal0};
    assign act1 = {ImmSel1, stall1, flush1, pcSel1, ex_ASel1, ex_BSel1, ex_ALUSel1, ex_BrUn1,
                   fwdA1, fwdB1, mem_MemRW1, mem_sign1, mem_size1, wb_RegWEn1, wb_WBSel1,
                   wb_rd1, illegal1};

    localparam logic [3:0] ALU_TAB [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    localparam logic [6:0] OPS [14] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h63, 7'h03,
                                        7'h03, 7'h23, 7'h13, 7'h13, 7'h33, 7'h33, 7'h7F};

    int    checks = 0;
    int    failures = 0;
    outs_t q0[$];
    outs_t q1[$];

    logic [31:0] cur_inst [2];
    logic        cur_valid [2];
    logic        hold [2];
    logic        squash [2];
    ins_t        p_ex [2];
    ins_t        p_mem [2];
    ins_t        p_wb [2];

    function automatic ins_t model_decode(input logic [31:0] i, input logic v);
        ins_t d;
        logic wr, r1, r2;
        d = '0; wr = 1'b0; r1 = 1'b0; r2 = 1'b0;
        if (v) begin
            d.f3 = i[14:12];
            case (i[6:0])
                7'h37: begin d.imm = 3'd3; d.b_sel = 1'b1; d.alu = 4'd10; d.wbs = 2'd1; wr = 1'b1; end
                7'h17: begin d.imm = 3'd3; d.a_sel = 1'b1; d.b_sel = 1'b1; d.wbs = 2'd1; wr = 1'b1; end
                7'h6F: begin d.imm = 3'd4; d.a_sel = 1'b1; d.b_sel = 1'b1; d.wbs = 2'd2; wr = 1'b1; d.jmp = 1'b1; end
                7'h67: begin d.b_sel = 1'b1; d.wbs = 2'd2; wr = 1'b1; d.jmp = 1'b1; r1 = 1'b1; end
                7'h63: begin d.imm = 3'd2; d.a_sel = 1'b1; d.b_sel = 1'b1; d.br = 1'b1;
                             d.br_un = i[13]; r1 = 1'b1; r2 = 1'b1; end
                7'h03: begin d.b_sel = 1'b1; wr = 1'b1; d.ld = 1'b1; d.sgn = ~i[14];
                             d.sz = i[13:12]; r1 = 1'b1; end
                7'h23: begin d.imm = 3'd1; d.b_sel = 1'b1; d.st = 1'b1; d.sz = i[13:12];
                             r1 = 1'b1; r2 = 1'b1; end
                7'h13: begin
                    d.b_sel = 1'b1; d.wbs = 2'd1; wr = 1'b1; r1 = 1'b1;
                    d.alu = (i[30] && i[14:12] == 3'd5) ? 4'd7 : ALU_TAB[i[14:12]];
                end
                7'h33: begin
                    d.wbs = 2'd1; wr = 1'b1; r1 = 1'b1; r2 = 1'b1;
                    if (i[30] && i[14:12] == 3'd0)      d.alu = 4'd1;
                    else if (i[30] && i[14:12] == 3'd5) d.alu = 4'd7;
                    else                                d.alu = ALU_TAB[i[14:12]];
                end
                default: d.ill = 1'b1;
            endcase
            if (wr && i[11:7] != 5'd0) begin d.w = 1'b1; d.rd = i[11:7]; end
            if (r1) d.rs1 = i[19:15];
            if (r2) d.rs2 = i[24:20];
        end
        return d;
    endfunction

    function automatic logic br_cond(input logic [2:0] f3, input logic eq, input logic lt);
        if (f3[2:1] == 2'b01) return 1'b0;
        return (f3[2] ? lt : eq) ^ f3[0];
    endfunction

    function automatic logic reads(input ins_t c, input logic [4:0] r);
        return (r != 5'd0) && (c.rs1 == r || c.rs2 == r);
    endfunction

    function automatic logic [1:0] fsel(input logic en, input ins_t m, input ins_t w, input logic [4:0] r);
        if (!en || r == 5'd0)               return 2'd0;
        if (m.w && !m.ld && m.rd == r)      return 2'd1;
        if (w.w && w.rd == r)               return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] i;
        i = $urandom;
        i[6:0]   = OPS[$urandom_range(0, 13)];
        i[11:7]  = 5'($urandom_range(0, 3));
        i[19:15] = 5'($urandom_range(0, 3));
        i[24:20] = 5'($urandom_range(0, 3));
        return i;
    endfunction

    // One cycle of the model for instance c: expected outputs, then advance.
    task automatic model_cycle(input int c, output outs_t e);
        ins_t id, x, m, w;
        logic taken, haz, fwd_en;
        fwd_en = (c == 0);
        id = model_decode(cur_inst[c], cur_valid[c]);
        x = p_ex[c]; m = p_mem[c]; w = p_wb[c];
        taken = x.jmp || (x.br && br_cond(x.f3, brEq, brLT));
        if (fwd_en)
            haz = x.ld && x.w && reads(id, x.rd);
        else
            haz = (x.w && reads(id, x.rd)) || (m.w && reads(id, m.rd)) || (w.w && reads(id, w.rd));
        e = '0;
        e.imm = id.imm;
        e.stall = haz && !taken;
        e.flush = taken;
        e.pc_sel = taken;
        e.a_sel = x.a_sel; e.b_sel = x.b_sel; e.alu = x.alu; e.br_un = x.br_un;
        e.fwd_a = fsel(fwd_en, m, w, x.rs1);
        e.fwd_b = fsel(fwd_en, m, w, x.rs2);
        e.mem_rw = m.st; e.sign = m.sgn; e.size = m.sz;
        e.reg_wen = w.w; e.wb_sel = w.wbs; e.rd = w.rd;
        e.illegal = (c == 1) && x.ill;
        if (rst_n) begin
            p_wb[c]  = m;
            p_mem[c] = x;
            p_ex[c]  = (taken || haz) ? '0 : id;
        end
    endtask

    task automatic chk(input string tag, input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s %s: got %0h expected %0h at %0t", tag, name, a, e, $time);
        end
    endtask

    task automatic check_bundle(input string tag, input outs_t a, input outs_t e);
        chk(tag, "ImmSel",    32'(a.imm),     32'(e.imm));
        chk(tag, "stall",     32'(a.stall),   32'(e.stall));
        chk(tag, "flush",     32'(a.flush),   32'(e.flush));
        chk(tag, "pcSel",     32'(a.pc_sel),  32'(e.pc_sel));
        chk(tag, "ex_ASel",   32'(a.a_sel),   32'(e.a_sel));
        chk(tag, "ex_BSel",   32'(a.b_sel),   32'(e.b_sel));
        chk(tag, "ex_ALUSel", 32'(a.alu),     32'(e.alu));
        chk(tag, "ex_BrUn",   32'(a.br_un),   32'(e.br_un));
        chk(tag, "fwdA",      32'(a.fwd_a),   32'(e.fwd_a));
        chk(tag, "fwdB",      32'(a.fwd_b),   32'(e.fwd_b));
        chk(tag, "mem_MemRW", 32'(a.mem_rw),  32'(e.mem_rw));
        chk(tag, "mem_sign",  32'(a.sign),    32'(e.sign));
        chk(tag, "mem_size",  32'(a.size),    32'(e.size));
        chk(tag, "wb_RegWEn", 32'(a.reg_wen), 32'(e.reg_wen));
        chk(tag, "wb_WBSel",  32'(a.wb_sel),  32'(e.wb_sel));
        chk(tag, "wb_rd",     32'(a.rd),      32'(e.rd));
        chk(tag, "illegal",   32'(a.illegal), 32'(e.illegal));
    endtask

    // Monitor: every cycle each instance presents a full output set mid-cycle.
    always @(negedge clk) begin
        outs_t e;
        if (q0.size() > 0) begin e = q0.pop_front(); check_bundle("fwd", act0, e); end
        if (q1.size() > 0) begin e = q1.pop_front(); check_bundle("stall", act1, e); end
    end

    // Stimulus: per-instance instruction stream, held on stall and squashed on flush.
    initial begin
        outs_t e;
        rst_n = 1'b0; brEq = 1'b0; brLT = 1'b0;
        inst0 = '0; inst1 = '0; valid0 = 1'b0; valid1 = 1'b0;
        for (int c = 0; c < 2; c++) begin
            hold[c] = 1'b0; squash[c] = 1'b0; cur_inst[c] = '0; cur_valid[c] = 1'b0;
            p_ex[c] = '0; p_mem[c] = '0; p_wb[c] = '0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            rst_n = !(cyc < 4 || (cyc >= 1500 && cyc < 1503));
            brEq  = 1'($urandom);
            brLT  = 1'($urandom);
            for (int c = 0; c < 2; c++) begin
                if (!rst_n) begin
                    p_ex[c] = '0; p_mem[c] = '0; p_wb[c] = '0;
                    hold[c] = 1'b0; squash[c] = 1'b0;
                    cur_valid[c] = 1'b0; cur_inst[c] = $urandom;
                end else if (squash[c]) begin
                    cur_valid[c] = 1'b0; cur_inst[c] = $urandom;
                end else if (!hold[c]) begin
                    cur_inst[c] = gen_inst();
                    cur_valid[c] = ($urandom_range(0, 9) != 0);
                end
            end
            inst0 = cur_inst[0]; valid0 = cur_valid[0];
            inst1 = cur_inst[1]; valid1 = cur_valid[1];
            for (int c = 0; c < 2; c++) begin
                model_cycle(c, e);
                hold[c] = e.stall;
                squash[c] = e.flush;
                if (c == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
        @(negedge clk);
        #1;
        chk("end", "q0_drained", 32'(q0.size()), 32'd0);
        chk("end", "q1_drained", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
